// File: rtl/ct_fspu_vec_pkg.sv
// Shared types, constants and per-element helpers for the vector FP sign/class/min-max unit.
// Elements are handled zero-extended in the low bits of a 64-bit word.
package ct_fspu_vec_pkg;

  typedef enum logic [2:0] {
    OP_FSGNJ  = 3'd0,
    OP_FSGNJN = 3'd1,
    OP_FSGNJX = 3'd2,
    OP_FCLASS = 3'd3,
    OP_FMVVF  = 3'd4,
    OP_FMVXF  = 3'd5,
    OP_FMIN   = 3'd6,
    OP_FMAX   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SEW_RSVD = 2'b00,
    SEW_H    = 2'b01,
    SEW_S    = 2'b10,
    SEW_D    = 2'b11
  } sew_e;

  localparam logic [63:0] CNAN_H = 64'h0000_0000_0000_7e00;
  localparam logic [63:0] CNAN_S = 64'h0000_0000_7fc0_0000;
  localparam logic [63:0] CNAN_D = 64'h7ff8_0000_0000_0000;

  localparam logic [63:0] BOX_H = 64'hffff_ffff_ffff_0000;
  localparam logic [63:0] BOX_S = 64'hffff_ffff_0000_0000;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  typedef struct packed {
    logic sign;
    logic inf;
    logic nan;
    logic snan;
    logic zero;
    logic sub;
  } fp_cls_t;

  typedef struct packed {
    logic        nv;
    logic [63:0] res;
  } elem_res_t;

  function automatic logic [63:0] elem_mask(sew_e sew);
    case (sew)
      SEW_H:   return 64'h0000_0000_0000_ffff;
      SEW_S:   return 64'h0000_0000_ffff_ffff;
      SEW_D:   return '1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] sign_bit(sew_e sew);
    case (sew)
      SEW_H:   return 64'h0000_0000_0000_8000;
      SEW_S:   return 64'h0000_0000_8000_0000;
      SEW_D:   return 64'h8000_0000_0000_0000;
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] canon_nan(sew_e sew);
    case (sew)
      SEW_H:   return CNAN_H;
      SEW_S:   return CNAN_S;
      SEW_D:   return CNAN_D;
      default: return '0;
    endcase
  endfunction

  function automatic logic [63:0] box_fill(sew_e sew);
    case (sew)
      SEW_H:   return BOX_H;
      SEW_S:   return BOX_S;
      default: return '0;
    endcase
  endfunction

  // Scalar operands that are not properly NaN-boxed read as the canonical NaN.
  function automatic logic [63:0] nanbox_check(sew_e sew, logic [63:0] x);
    case (sew)
      SEW_H:   return ((x & BOX_H) == BOX_H) ? x : CNAN_H;
      SEW_S:   return ((x & BOX_S) == BOX_S) ? x : CNAN_S;
      default: return x;
    endcase
  endfunction

  function automatic fp_cls_t classify(sew_e sew, logic [63:0] x);
    fp_cls_t c;
    logic    exp_ones, exp_zero, man_zero, quiet;
    case (sew)
      SEW_H: begin
        exp_ones = &x[14:10]; exp_zero = ~|x[14:10]; man_zero = ~|x[9:0];  quiet = x[9];
      end
      SEW_S: begin
        exp_ones = &x[30:23]; exp_zero = ~|x[30:23]; man_zero = ~|x[22:0]; quiet = x[22];
      end
      SEW_D: begin
        exp_ones = &x[62:52]; exp_zero = ~|x[62:52]; man_zero = ~|x[51:0]; quiet = x[51];
      end
      default: begin
        exp_ones = 1'b0; exp_zero = 1'b1; man_zero = 1'b1; quiet = 1'b0;
      end
    endcase
    c.sign = |(x & sign_bit(sew));
    c.inf  = exp_ones & man_zero;
    c.nan  = exp_ones & ~man_zero;
    c.snan = c.nan & ~quiet;
    c.zero = exp_zero & man_zero;
    c.sub  = exp_zero & ~man_zero;
    return c;
  endfunction

  function automatic logic [9:0] fclass_bits(fp_cls_t c);
    logic [9:0] f;
    logic       norm;
    norm = ~c.inf & ~c.nan & ~c.zero & ~c.sub;
    f = '0;
    f[CLS_NEG_INF]  = c.sign & c.inf;
    f[CLS_NEG_NORM] = c.sign & norm;
    f[CLS_NEG_SUB]  = c.sign & c.sub;
    f[CLS_NEG_ZERO] = c.sign & c.zero;
    f[CLS_POS_ZERO] = ~c.sign & c.zero;
    f[CLS_POS_SUB]  = ~c.sign & c.sub;
    f[CLS_POS_NORM] = ~c.sign & norm;
    f[CLS_POS_INF]  = ~c.sign & c.inf;
    f[CLS_SNAN]     = c.snan;
    f[CLS_QNAN]     = c.nan & ~c.snan;
    return f;
  endfunction

  function automatic elem_res_t elem_op(op_e op, sew_e sew, logic [63:0] a, logic [63:0] b,
                                        logic [63:0] mv);
    elem_res_t   r;
    fp_cls_t     ca, cb;
    logic [63:0] mask, sb, mag_a, mag_b;
    logic        lt;
    mask  = elem_mask(sew);
    sb    = sign_bit(sew);
    ca    = classify(sew, a);
    cb    = classify(sew, b);
    mag_a = a & mask & ~sb;
    mag_b = b & mask & ~sb;
    // Sign-magnitude ordering; differing signs also make -0 < +0.
    if (ca.sign != cb.sign) lt = ca.sign;
    else if (!ca.sign)      lt = mag_a < mag_b;
    else                    lt = mag_a > mag_b;
    r = '0;
    case (op)
      OP_FSGNJ:  r.res = mag_a | (b & sb);
      OP_FSGNJN: r.res = mag_a | (~b & sb);
      OP_FSGNJX: r.res = mag_a | ((a ^ b) & sb);
      OP_FCLASS: r.res = {54'b0, fclass_bits(ca)};
      OP_FMVVF:  r.res = mv & mask;
      OP_FMIN, OP_FMAX: begin
        r.nv = ca.snan | cb.snan;
        if (ca.nan && cb.nan)          r.res = canon_nan(sew);
        else if (ca.nan)               r.res = b & mask;
        else if (cb.nan)               r.res = a & mask;
        else if ((op == OP_FMIN) == lt) r.res = a & mask;
        else                           r.res = b & mask;
      end
      default:   r.res = '0;
    endcase
    if (sew == SEW_RSVD) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/ct_fspu_lane.sv
// One 64-bit lane: splits into 4x16 / 2x32 / 1x64 elements and applies the op to each.
module ct_fspu_lane
  import ct_fspu_vec_pkg::*;
(
  input  op_e         op,
  input  sew_e        sew,
  input  logic        elem0_only,
  input  logic [63:0] oper0,
  input  logic [63:0] oper1,
  input  logic [63:0] mv_src,
  output logic [63:0] result,
  output logic        nv
);

  always_comb begin
    elem_res_t r;
    // NOTE: every output gets a default first so no path through the case infers a latch.
    r      = '0;
    result = '0;
    nv     = 1'b0;
    case (sew)
      SEW_H: begin
        for (int i = 0; i < 4; i++) begin
          r = elem_op(op, sew, {48'b0, oper0[i*16 +: 16]}, {48'b0, oper1[i*16 +: 16]}, mv_src);
          result[i*16 +: 16] = r.res[15:0];
          nv = nv | (r.nv & (!elem0_only || (i == 0)));
        end
      end
      SEW_S: begin
        for (int i = 0; i < 2; i++) begin
          r = elem_op(op, sew, {32'b0, oper0[i*32 +: 32]}, {32'b0, oper1[i*32 +: 32]}, mv_src);
          result[i*32 +: 32] = r.res[31:0];
          nv = nv | (r.nv & (!elem0_only || (i == 0)));
        end
      end
      SEW_D: begin
        r      = elem_op(op, sew, oper0, oper1, mv_src);
        result = r.res;
        nv     = r.nv;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ct_fspu_vec.sv
// Vector FP sign-inject / class / move / min-max unit; issues in EX1, registered result in EX2.
module ct_fspu_vec
  import ct_fspu_vec_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                ex1_sel,
  input  logic [2:0]          ex1_op,
  input  logic [1:0]          ex1_sew,
  input  logic                ex1_scalar,
  input  logic [64*LANES-1:0] ex1_oper0,
  input  logic [64*LANES-1:0] ex1_oper1,
  input  logic [63:0]         mtvr_src0,
  input  logic                ex2_stall,
  input  logic                rtu_flush,
  output logic                ex1_ready,
  output logic                ex2_result_vld,
  output logic [64*LANES-1:0] ex2_result,
  output logic [63:0]         ex2_result_fmfvr,
  output logic [4:0]          ex2_fflags
);

  localparam int W = 64 * LANES;

  op_e              op;
  sew_e             sew;
  logic [W-1:0]     src0, src1, lane_res, res_d;
  logic [63:0]      mv, fmfvr_d;
  logic [LANES-1:0] lane_nv;
  logic             nv_d, accept;

  assign op        = op_e'(ex1_op);
  assign sew       = sew_e'(ex1_sew);
  assign ex1_ready = ~ex2_stall;
  assign accept    = ex1_sel & ~ex2_stall & ~rtu_flush;

  always_comb begin
    src0 = ex1_oper0;
    src1 = ex1_oper1;
    mv   = mtvr_src0;
    if (ex1_scalar) begin
      src0[63:0] = nanbox_check(sew, ex1_oper0[63:0]);
      src1[63:0] = nanbox_check(sew, ex1_oper1[63:0]);
      mv         = nanbox_check(sew, mtvr_src0);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ct_fspu_lane u_lane (
      .op         (op),
      .sew        (sew),
      .elem0_only (ex1_scalar),
      .oper0      (src0[g*64 +: 64]),
      .oper1      (src1[g*64 +: 64]),
      .mv_src     (mv),
      .result     (lane_res[g*64 +: 64]),
      .nv         (lane_nv[g])
    );
  end

  always_comb begin
    res_d   = '0;
    fmfvr_d = '0;
    nv_d    = 1'b0;
    if (ex1_scalar) begin
      res_d[63:0] = (lane_res[63:0] & elem_mask(sew)) | box_fill(sew);
      nv_d        = lane_nv[0];
    end else begin
      res_d = lane_res;
      nv_d  = |lane_nv;
    end
    if (op == OP_FMVXF) begin
      res_d = '0;
      case (sew)
        SEW_H:   fmfvr_d = {{48{src0[15]}}, src0[15:0]};
        SEW_S:   fmfvr_d = {{32{src0[31]}}, src0[31:0]};
        SEW_D:   fmfvr_d = src0[63:0];
        default: fmfvr_d = '0;
      endcase
    end
  end

  // Flush clears vld even under stall; data registers only load on an accepted op.
  always_ff @(posedge forever_cpuclk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (cpurst) begin
      ex2_result_vld   <= 1'b0;
      ex2_result       <= '0;
      ex2_result_fmfvr <= '0;
      ex2_fflags       <= '0;
    end else begin
      if (rtu_flush)      ex2_result_vld <= 1'b0;
      else if (!ex2_stall) ex2_result_vld <= ex1_sel;
      if (accept) begin
        ex2_result       <= res_d;
        ex2_result_fmfvr <= fmfvr_d;
        ex2_fflags       <= {nv_d, 4'b0000};
      end
    end
  end

endmodule

// File: doc/ct_fspu_vec.md
Name: ct_fspu_vec

Overview:
- Parametrised, pipelined successor to the single-precision FSPU.
- Performs sign-injection (fsgnj/n/x), fclass, fmv.v.f broadcast, fmv.x.f, fmin and fmax on LANES x 64-bit lanes.
- Each lane splits into elements by SEW: 16, 32 or 64 bit.
- Sits in the vector FALU EX1->EX2 path: ops issue in EX1, and one registered result with NV flag returns in EX2 under stall/flush control.

Parameters:
- LANES, 2, number of 64-bit lanes; datapath width is 64*LANES.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous, active-high reset.
- ex1_sel  in  1  op valid in EX1.
- ex1_op  in  3  0 fsgnj, 1 fsgnjn, 2 fsgnjx, 3 fclass, 4 fmvvf, 5 fmvxf, 6 fmin, 7 fmax.
- ex1_sew  in  2  01 half, 10 single, 11 double; 00 reserved.
- ex1_scalar  in  1  scalar op: NaN-box check applies, element 0 of lane 0 only.
- ex1_oper0  in  64*LANES  source 0.
- ex1_oper1  in  64*LANES  source 1.
- mtvr_src0  in  64  integer source for fmvvf.
- ex2_stall  in  1  downstream hold.
- rtu_flush  in  1  kill EX1 and EX2.
- ex1_ready  out  1  = !ex2_stall; an op is accepted when ex1_sel && ex1_ready && !rtu_flush.
- ex2_result_vld  out  1  EX2 holds a valid result.
- ex2_result  out  64*LANES  FP/vector result.
- ex2_result_fmfvr  out  64  fmvxf result.
- ex2_fflags  out  5  {NV,DZ,OF,UF,NX}; only NV can be set.

Behaviour:
- Reset: ex2_result_vld=0, ex2_result=0, ex2_result_fmfvr=0, ex2_fflags=0.
- Latency: 1 cycle. Accepted op in cycle N -> ex2_result_vld=1 in N+1.
- ex2_stall=1: all EX2 registers hold; ex1_ready=0; ex1_sel ignored.
- rtu_flush=1: ex2_result_vld cleared next cycle regardless of stall (flush beats stall); a same-cycle EX1 op is dropped. Data registers may keep stale values.
- Idle cycle (no accept, no stall): ex2_result_vld -> 0.
- NaN-box check (ex1_scalar only):
  - Half: oper[63:16] must be all ones, else replaced by 0x7e00.
  - Single: oper[63:32] must be all ones, else replaced by 0x7fc00000.
  - Double: no check.
  - Applies to oper0 and oper1, and to mtvr_src0 for fmvvf.
- Scalar result: element in low SEW bits of lane 0, bits above SEW set to ones (NaN-boxed), other lanes 0.
- Vector (ex1_scalar=0): each element processed independently, no NaN-box check.
- fsgnj/n/x: magnitude from oper0; sign = s1, ~s1 or s0^s1 respectively.
- fclass: 10-bit class, bit 0 neg-inf ... bit 9 qNaN, same order as the single unit; zero-extended to element width.
- fmvvf: mtvr_src0 low SEW bits (after NaN-box check when scalar) broadcast to every element; scalar writes element 0 only.
- fmvxf: ex2_result_fmfvr = oper0 element 0 sign-extended to 64 bits (double passes through). ex2_result = 0.
- fmin/fmax (IEEE 754-2019 minimumNumber/maximumNumber):
  - One NaN -> return the other operand.
  - Both NaN -> canonical NaN (0x7e00 / 0x7fc00000 / 0x7ff8000000000000).
  - -0 < +0.
  - NV set if any active element input is sNaN.
- NV: OR over active elements of fmin/fmax only; all other ops give fflags=0.
- ex1_sew=00 with ex1_sel: result 0, fflags 0, vld still asserted.

Decomposition:
- Package ct_fspu_vec_pkg:
  - op codes, SEW codes;
  - canonical NaN constants per SEW;
  - fclass bit positions;
  - NaN-box fill masks.
- Sub-module ct_fspu_lane:
  - combinational; one 64-bit lane, instantiated LANES times;
  - handles 4x16 / 2x32 / 1x64 element split;
  - outputs lane result and lane NV.
- Top module: NaN-box check, lane generate loop, scalar masking, fmfvr select, EX2 pipeline registers.

Test Plan:
- Scalar fsgnjx single: oper0=FFFFFFFF_3F800000, oper1=FFFFFFFF_BF800000 -> cycle+1 vld=1, lane0=FFFFFFFF_BF800000, lane1=0, fflags=0.
- Scalar fclass single with failed NaN-box: oper0=00000000_3F800000 -> lane0 low 32 = 0x00000200 (qNaN), upper ones.
- Vector fmin single LANES=2:
  - lane0 elements {7F800001, 80000000}, oper1 {40000000, 00000000} -> {40000000, 80000000}, NV=1.
  - Both-NaN element pair -> 7FC00000.
- Vector fsgnjn half: oper0 lane0=3C00_3C00_BC00_BC00, oper1=0000_8000_0000_8000 -> BC00_3C00_BC00_3C00.
- Stall/flush:
  - Accept op, then ex2_stall=1 for 2 cycles -> result and vld held, ex1_ready=0.
  - Then rtu_flush with stall still 1 -> vld=0 next cycle.
  - Reset mid-stream -> all outputs 0 the next cycle.
- fmvxf half: oper0 lane0 low16=0x8001 -> ex2_result_fmfvr=FFFFFFFF_FFFF8001.
- fmvvf scalar single: mtvr_src0=00000000_12345678 -> lane0=FFFFFFFF_7FC00000.
